// File: rtl/step_pulse_generator.sv
// Turns a bouncy pushbutton and an optional periodic timer into single-cycle step strobes.
// The button is synchronized, debounced by a 4-state FSM, and OR-ed with the auto-step tick.
module step_pulse_generator #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned TICK_DIVISOR    = 100000000
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  input  logic auto_mode,
  output logic enable,
  output logic pressed
);

  localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TickW = $clog2(TICK_DIVISOR);

  localparam logic [CntW-1:0]  CntMax  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIVISOR - 1);

  typedef enum logic [1:0] {
    StIdleLow  = 2'd0,
    StWaitHigh = 2'd1,
    StIdleHigh = 2'd2,
    StWaitLow  = 2'd3
  } state_e;

  // Button synchronizer; only the last stage is ever looked at.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce FSM
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_pulse;
  logic            pressed_q, pressed_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_pulse = 1'b0;
    case (state_q)
      StIdleLow: begin
        if (s) begin
          state_d = StWaitHigh;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StWaitHigh: begin
        if (!s) begin
          state_d = StIdleLow;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d     = StIdleHigh;
          cnt_d       = '0;
          press_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StIdleHigh: begin
        if (!s) begin
          state_d = StWaitLow;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StWaitLow: begin
        // Releases settle the level only; they never produce a step.
        if (s) begin
          state_d = StIdleHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StIdleLow;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdleLow;
        cnt_d   = '0;
      end
    endcase
  end

  assign pressed_d = (state_d == StIdleHigh) || (state_d == StWaitLow);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdleLow;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
    end
  end

  // Auto-step tick; free-running and independent of button activity.
  logic [TickW-1:0] tcnt_q, tcnt_d;
  logic             tick_pulse;

  always_comb begin
    tick_pulse = 1'b0;
    tcnt_d     = '0;
    if (auto_mode) begin
      if (tcnt_q == TickMax) begin
        tick_pulse = 1'b1;
      end else begin
        tcnt_d = tcnt_q + TickW'(1);
      end
    end
  end

  logic enable_q, enable_d;

  // Coincident press and tick merge into one strobe.
  assign enable_d = press_pulse | tick_pulse;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tcnt_q   <= '0;
      enable_q <= 1'b0;
    end else begin
      tcnt_q   <= tcnt_d;
      enable_q <= enable_d;
    end
  end

  assign enable  = enable_q;
  assign pressed = pressed_q;

endmodule
